adc_sample_sequencer: RTL and testbench
=======================================

Name: adc_sample_sequencer

Overview:
Sits between the system control logic and the max11100 SPI reader. Issues periodic single-cycle `trigger` pulses to the reader and captures each returned 16-bit sample. Accumulates 2^LOG2_AVG consecutive samples and emits their truncated mean as a one-cycle `avg_valid` strobe. Detects a reader that fails to return data within a timeout and flags it with a sticky error.

Parameters:
SAMPLE_PERIOD, 400, clocks between successive trigger pulses (trigger-to-trigger); must be > TIMEOUT+4
TIMEOUT, 300, clocks allowed from trigger to data_ready rising edge before the sample is abandoned
LOG2_AVG, 2, log2 of samples per average (1..8)
CNT_WIDTH, 16, width of period/timeout counters; must hold SAMPLE_PERIOD-1

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  1  level; 1 = run sampling, 0 = idle and abort
trigger  output  1  one-cycle pulse to ADC reader requesting a conversion
adc_data  input  16  sample from ADC reader, stable while adc_data_ready high
adc_data_ready  input  1  ADC reader data-ready; a 0->1 transition marks a new sample
avg_data  output  16  mean of last 2^LOG2_AVG samples, held until next update
avg_valid  output  1  one-cycle strobe when avg_data updates
timeout_err  output  1  sticky: a conversion timed out since last enable rise

Behaviour:
- Interface: one clock `clk`; reset `resetn` is asynchronous and active-low. All state is cleared on its assertion regardless of clk.
- Reset values: trigger=0, avg_data=0, avg_valid=0, timeout_err=0, state=IDLE, accumulator=0, sample count=0, ready_q=0.
- Edge detect: ready_q registers adc_data_ready each clock. A rising edge is a clock where ready_q=0 and adc_data_ready=1.
- FSM states:
  - IDLE: wait for enable. enable=1 -> TRIG.
  - TRIG: trigger=1 for exactly this cycle; load period counter=0 and timeout counter=0 -> WAIT_DATA.
  - WAIT_DATA:
    - On a rising edge, accumulator += zero-extended adc_data and sample count += 1 -> WAIT_PERIOD.
    - If the timeout counter reaches TIMEOUT-1 with no edge: set timeout_err, leave accumulator and count unchanged -> WAIT_PERIOD.
  - WAIT_PERIOD: when the period counter reaches SAMPLE_PERIOD-1 -> TRIG.
    - Consequence: trigger rises every SAMPLE_PERIOD clocks exactly.
    - The period counter runs from TRIG through WAIT_DATA and WAIT_PERIOD.
    - A rising edge outside WAIT_DATA is ignored.
- First trigger: asserted on the clock after enable is first sampled high.
- Averaging:
  - Accumulator is 16+LOG2_AVG bits, so it never overflows.
  - When the capture brings sample count to 2^LOG2_AVG: on the next clock, avg_data = accumulator >> LOG2_AVG (truncate), avg_valid=1 for one cycle, and accumulator and count clear to 0.
  - Latency: final sample's rising-edge clock + 1.
- enable=0 in any state: next clock -> IDLE, trigger=0, accumulator and count cleared, pending average discarded (no avg_valid). avg_data retains its last value.
- timeout_err: cleared on the enable 0->1 transition; otherwise sticky until reset.
- Simultaneous timeout expiry and rising edge in the same cycle: the edge wins; the sample is captured and timeout_err is not set.
- Reset mid-conversion: everything returns to reset values. The ADC reader is reset by the same resetn.

Decomposition:
- Shared package/include holds:
  - state encodings IDLE=2'd0, TRIG=2'd1, WAIT_DATA=2'd2, WAIT_PERIOD=2'd3
  - ADC_WIDTH=16
- One natural sub-module: adc_period_timer.
  - Wraps the period and timeout counters.
  - Inputs: clear/start.
  - Outputs: period_done and timeout_done.

Test Plan:
- Constant sample: max11100 + MISO model driving 0x1234 every conversion, enable=1 -> four triggers 400 clocks apart; avg_valid once with avg_data=0x1234; trigger count measured between rising edges = 400.
- Varying samples 0x0001, 0x0002, 0x0003, 0x0004 -> avg_data=0x0002 (sum 10 >> 2); second group 0xFFFF×4 -> avg_data=0xFFFF with no overflow.
- Timeout: hold adc_data_ready=0 after the first trigger -> timeout_err=1 exactly 300 clocks after the trigger; next trigger still at +400; no avg_valid until 4 successful samples have been collected.
- Enable abort: drop enable after 2 captured samples, re-raise 10 clocks later -> trigger on the clock after re-enable, timeout_err cleared; avg_valid only after 4 new samples; a mix of old and new samples must not be averaged.
- Edge/timeout collision: rising edge on the same clock as timeout expiry -> sample accepted, timeout_err stays 0.
- Async reset mid-WAIT_DATA: resetn low between clock edges -> all outputs 0 immediately; after release with enable=1, normal sequence resumes and first avg_data=0x1234.

Source files
------------

// File: rtl/adc_sample_sequencer_pkg.sv
// adc_sample_sequencer_pkg
// Types and constants shared by the ADC sample sequencer, its period timer
// and its reader-side interface.
//   state_t   : sequencer FSM encoding
//   ADC_WIDTH : width of one sample returned by the ADC reader
package adc_sample_sequencer_pkg;

  localparam int ADC_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    TRIG        = 2'd1,
    WAIT_DATA   = 2'd2,
    WAIT_PERIOD = 2'd3
  } state_t;

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if
// Handshake between the sequencer and the max11100 SPI reader.
//   trigger        : one-cycle conversion request (sequencer -> reader)
//   adc_data       : sample, stable while adc_data_ready is high (reader -> sequencer)
//   adc_data_ready : a 0->1 transition marks a new sample (reader -> sequencer)
// Modports: master = sequencer side, slave = reader side.
interface adc_sample_sequencer_if;
  import adc_sample_sequencer_pkg::*;

  logic                 trigger;
  logic [ADC_WIDTH-1:0] adc_data;
  logic                 adc_data_ready;

  modport master (output trigger, input adc_data, input adc_data_ready);
  modport slave  (input trigger, output adc_data, output adc_data_ready);
endinterface

// File: rtl/adc_sample_sequencer_period_timer.sv
// adc_period_timer
// Trigger-to-trigger period counter plus trigger-to-data timeout counter.
// Both counters read 0 during the start (trigger) cycle, so a done flag
// raised at count N-1 lets the FSM act exactly N clocks after the trigger.
//   clk, resetn  : clock, asynchronous active-low reset
//   clear        : hold both counters at zero (sequencer idle)
//   start        : trigger cycle; counters restart from zero
//   run_timeout  : timeout counter advances only while waiting for data
//   period_done  : period counter at SAMPLE_PERIOD-1
//   timeout_done : timeout counter at TIMEOUT-1 while waiting
module adc_period_timer #(
  parameter int SAMPLE_PERIOD = 400,
  parameter int TIMEOUT       = 300,
  parameter int CNT_WIDTH     = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic start,
  input  logic run_timeout,
  output logic period_done,
  output logic timeout_done
);

  logic [CNT_WIDTH-1:0] period_q, timeout_q;
  logic [CNT_WIDTH-1:0] period_now, timeout_now;

  // NOTE: the values are assigned on every path, so no latch is inferred.
  always_comb begin
    period_now  = start ? '0 : period_q;
    timeout_now = start ? '0 : timeout_q;
  end

  assign period_done  = (period_now == CNT_WIDTH'(SAMPLE_PERIOD - 1));
  assign timeout_done = run_timeout && (timeout_now == CNT_WIDTH'(TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      period_q  <= '0;
      timeout_q <= '0;
    end else if (clear) begin
      period_q  <= '0;
      timeout_q <= '0;
    end else begin
      period_q <= period_now + CNT_WIDTH'(1);
      if (start || run_timeout) timeout_q <= timeout_now + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
// Issues periodic trigger pulses to the ADC reader, captures each returned
// sample on the rising edge of adc_data_ready, and emits the truncated mean
// of every 2^LOG2_AVG samples. A reader that does not answer within TIMEOUT
// clocks sets a sticky error, cleared on the next enable rise.
//   clk, resetn  : clock, asynchronous active-low reset
//   enable       : 1 = run, 0 = idle and abort the pending average
//   bus          : reader handshake (trigger / adc_data / adc_data_ready)
//   avg_data     : last average, held between updates
//   avg_valid    : one-cycle strobe when avg_data updates
//   timeout_err  : sticky conversion timeout flag
module adc_sample_sequencer
  import adc_sample_sequencer_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 400,
  parameter int TIMEOUT       = 300,
  parameter int LOG2_AVG      = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   enable,
  adc_sample_sequencer_if.master bus,
  output logic [ADC_WIDTH-1:0]   avg_data,
  output logic                   avg_valid,
  output logic                   timeout_err
);

  localparam int ACC_WIDTH  = ADC_WIDTH + LOG2_AVG;
  localparam int SCNT_WIDTH = LOG2_AVG + 1;
  localparam int AVG_COUNT  = 1 << LOG2_AVG;

  state_t                 state;
  logic                   trigger_q;
  logic                   ready_q;
  logic                   enable_q;
  logic [ACC_WIDTH-1:0]   acc;
  logic [SCNT_WIDTH-1:0]  sample_cnt;
  logic                   rise;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic                   period_done, timeout_done;

  assign bus.trigger = trigger_q;
  assign rise        = bus.adc_data_ready && !ready_q;
  assign acc_next    = acc + ACC_WIDTH'(bus.adc_data);

  adc_period_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .TIMEOUT      (TIMEOUT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_timer (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (state == IDLE),
    .start       (state == TRIG),
    .run_timeout (state == WAIT_DATA),
    .period_done (period_done),
    .timeout_done(timeout_done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      trigger_q   <= 1'b0;
      ready_q     <= 1'b0;
      enable_q    <= 1'b0;
      acc         <= '0;
      sample_cnt  <= '0;
      avg_data    <= '0;
      avg_valid   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      ready_q   <= bus.adc_data_ready;
      enable_q  <= enable;
      avg_valid <= 1'b0;

      if (enable && !enable_q) timeout_err <= 1'b0;

      if (!enable) begin
        // Abort: any partial group is dropped so old and new samples never mix.
        state      <= IDLE;
        trigger_q  <= 1'b0;
        acc        <= '0;
        sample_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            state     <= TRIG;
            trigger_q <= 1'b1;
          end
          TRIG: begin
            state     <= WAIT_DATA;
            trigger_q <= 1'b0;
          end
          WAIT_DATA: begin
            // The edge is tested first so it wins over a coincident timeout.
            if (rise) begin
              state <= WAIT_PERIOD;
              if (sample_cnt == SCNT_WIDTH'(AVG_COUNT - 1)) begin
                avg_data   <= ADC_WIDTH'(acc_next >> LOG2_AVG);
                avg_valid  <= 1'b1;
                acc        <= '0;
                sample_cnt <= '0;
              end else begin
                acc        <= acc_next;
                sample_cnt <= sample_cnt + SCNT_WIDTH'(1);
              end
            end else if (timeout_done) begin
              state       <= WAIT_PERIOD;
              timeout_err <= 1'b1;
            end
          end
          WAIT_PERIOD: begin
            if (period_done) begin
              state     <= TRIG;
              trigger_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer
// Directed bench: a reader model answers each trigger from a queue of
// (value, delay) entries; expected averages go into a scoreboard queue that
// a monitor pops on every avg_valid strobe. A second monitor checks the
// trigger-to-trigger spacing while the sequencer runs uninterrupted.
module tb_adc_sample_sequencer;
  import adc_sample_sequencer_pkg::*;

  localparam int PERIOD = 400;
  localparam int TMO    = 300;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] avg_data;
  logic        avg_valid;
  logic        timeout_err;

  adc_sample_sequencer_if bus ();

  adc_sample_sequencer #(
    .SAMPLE_PERIOD(PERIOD),
    .TIMEOUT      (TMO),
    .LOG2_AVG     (2),
    .CNT_WIDTH    (16)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .bus        (bus),
    .avg_data   (avg_data),
    .avg_valid  (avg_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    int          delay;  // clocks after the trigger cycle; -1 = never answer
  } sample_t;

  sample_t     sample_q[$];
  logic [15:0] exp_q[$];
  int tests = 0, fails = 0, avg_seen = 0, cyc = 0;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic push_sample(logic [15:0] val, int delay);
    sample_t s;
    s.val   = val;
    s.delay = delay;
    sample_q.push_back(s);
  endtask

  task automatic wait_avgs(int n, int budget);
    int k = 0;
    while (avg_seen < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("avg_count", avg_seen, n);
  endtask

  task automatic wait_trig(string name, int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.trigger && k < budget);
    check(name, bus.trigger, 1);
  endtask

  // Reader model, reset by the same resetn as the sequencer.
  initial begin : reader
    int      wait_cnt;
    int      hold;
    bit      pend;
    sample_t cur;
    bus.adc_data       = '0;
    bus.adc_data_ready = 1'b0;
    wait_cnt = 0;
    hold     = 0;
    pend     = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        bus.adc_data_ready = 1'b0;
        pend = 1'b0;
        hold = 0;
      end else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) bus.adc_data_ready = 1'b0;
        end
        if (bus.trigger) begin
          if (sample_q.size() > 0) cur = sample_q.pop_front();
          else begin
            cur.val   = 16'h1234;
            cur.delay = 20;
          end
          pend     = (cur.delay >= 0);
          wait_cnt = cur.delay;
        end else if (pend) begin
          if (wait_cnt <= 1) begin
            bus.adc_data       = cur.val;
            bus.adc_data_ready = 1'b1;
            hold = 5;
            pend = 1'b0;
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Trigger spacing monitor.
  initial begin : trig_mon
    int last_trig = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn || !enable) last_trig = -1;
      if (bus.trigger) begin
        if (last_trig >= 0) check("trig_interval", cyc - last_trig, PERIOD);
        last_trig = cyc;
      end
    end
  end

  // Average scoreboard monitor.
  initial begin : avg_mon
    forever begin
      @(negedge clk);
      if (avg_valid) begin
        avg_seen++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL avg_unexpected: got 0x%0h expected no strobe", avg_data);
        end else begin
          check("avg_data", avg_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin : main
    int k;
    resetn = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trigger", bus.trigger, 0);
    check("rst_avg_data", avg_data, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_timeout_err", timeout_err, 0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_no_trigger", bus.trigger, 0);

    // Constant, varying and full-scale groups.
    for (int i = 0; i < 4; i++) push_sample(16'h1234, 20);
    exp_q.push_back(16'h1234);
    push_sample(16'h0001, 5);
    push_sample(16'h0002, 50);
    push_sample(16'h0003, 150);
    push_sample(16'h0004, 1);
    exp_q.push_back(16'h0002);
    for (int i = 0; i < 4; i++) push_sample(16'hFFFF, 30 + 60 * i);
    exp_q.push_back(16'hFFFF);

    enable = 1'b1;
    @(negedge clk);
    check("first_trigger", bus.trigger, 1);
    wait_avgs(3, 6000);

    // Timeout: first conversion never answered.
    push_sample(16'h0BAD, -1);
    push_sample(16'h0010, 20);
    push_sample(16'h0020, 20);
    push_sample(16'h0030, 20);
    push_sample(16'h0070, 20);
    exp_q.push_back(16'h0034);
    wait_trig("timeout_trigger", 1000);
    check("timeout_err_before", timeout_err, 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!timeout_err && k < 500);
    check("timeout_latency", k, TMO);
    wait_avgs(4, 3000);
    check("timeout_sticky", timeout_err, 1);

    // Enable abort after two captured samples.
    push_sample(16'h7000, 20);
    push_sample(16'h7000, 20);
    wait_trig("abort_trig1", 1000);
    wait_trig("abort_trig2", 1000);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("disabled_no_trigger", bus.trigger, 0);
    repeat (9) @(negedge clk);
    check("sticky_while_disabled", timeout_err, 1);
    push_sample(16'h0008, 20);
    push_sample(16'h0010, 20);
    push_sample(16'h0018, 40);
    push_sample(16'h0020, 10);
    exp_q.push_back(16'h0014);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_trigger", bus.trigger, 1);
    check("timeout_err_cleared", timeout_err, 0);
    wait_avgs(5, 3000);

    // Rising edge on the same clock as timeout expiry.
    push_sample(16'h0200, TMO - 1);
    for (int i = 0; i < 3; i++) push_sample(16'h0200, 20);
    exp_q.push_back(16'h0200);
    wait_trig("collision_trigger", 1000);
    repeat (305) @(negedge clk);
    check("collision_no_err", timeout_err, 0);
    wait_avgs(6, 3000);

    // Asynchronous reset while waiting for data.
    push_sample(16'h5555, 100);
    wait_trig("reset_trigger", 1000);
    repeat (50) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_trigger", bus.trigger, 0);
    check("async_rst_avg_data", avg_data, 0);
    check("async_rst_avg_valid", avg_valid, 0);
    check("async_rst_timeout_err", timeout_err, 0);
    for (int i = 0; i < 4; i++) push_sample(16'h1234, 20);
    exp_q.push_back(16'h1234);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_reset_trigger", bus.trigger, 1);
    wait_avgs(7, 3000);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
